spart_driver: RTL

//  Bus-master stand-in for the processor; sits directly upstream of spart on its io bus.

---
 rtl/spart_driver_if.sv | 12 +
 rtl/spart_driver.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/spart_driver_if.sv
// spart io-bus signals between the driver (master) and spart (slave).
// The bidirectional databus is carried separately as a plain inout port.
interface spart_driver_if;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic       rda;
  logic       tbr;

  modport master (output iocs, iorw, ioaddr, input rda, tbr);
  modport slave  (input iocs, iorw, ioaddr, output rda, tbr);
endinterface

// File: rtl/spart_driver.sv
// spart_driver: programs the spart baud divisor from br_cfg, then runs a polled echo loop.
// Optional feature macro CASE_FOLD_EN: lowercase ASCII bytes are echoed as uppercase.
module spart_driver #(
  parameter int CLK_HZ   = 50_000_000,
  parameter int SYNC_STG = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [1:0]     br_cfg,
  spart_driver_if.master io,
  inout  wire  [7:0]     databus
);
  typedef enum logic [2:0] {
    CFG_HI, CFG_LO, IDLE, RD_RX, WAIT_TBR, WR_TX, HOLDOFF
  } state_t;

  function automatic logic [15:0] div_calc(input int baud);
    return 16'(((CLK_HZ + 8 * baud) / (16 * baud)) - 1);
  endfunction

  localparam logic [15:0] DIV_4800  = div_calc(4800);
  localparam logic [15:0] DIV_9600  = div_calc(9600);
  localparam logic [15:0] DIV_19200 = div_calc(19200);
  localparam logic [15:0] DIV_38400 = div_calc(38400);

  function automatic logic [7:0] fold(input logic [7:0] b);
`ifdef CASE_FOLD_EN
    return (b >= 8'h61 && b <= 8'h7A) ? b - 8'h20 : b;
`else
    return b;
`endif
  endfunction

  logic [2*SYNC_STG-1:0] sync_reg;
  logic [1:0]            cfg_sync;
  logic [1:0]            cfg_q;
  logic [15:0]           div_now;
  logic                  cfg_change;

  state_t      state_reg;
  logic        iocs_reg;
  logic        iorw_reg;
  logic [1:0]  ioaddr_reg;
  logic [7:0]  data_reg;
  logic [7:0]  hold_reg;
  logic [15:0] div_reg;
  logic        dirty_reg;

  // Synchroniser and cfg_q keep sampling while rst is held, so the first
  // reprogram after reset already sees the current switch setting.
  always_ff @(posedge clk) begin
    sync_reg <= {sync_reg[2*SYNC_STG-3:0], br_cfg};
    cfg_q    <= cfg_sync;
  end

  assign cfg_sync   = sync_reg[2*SYNC_STG-1 -: 2];
  assign cfg_change = (cfg_sync != cfg_q);

  always_comb begin
    case (cfg_q)
      2'b00:   div_now = DIV_4800;
      2'b01:   div_now = DIV_9600;
      2'b10:   div_now = DIV_19200;
      default: div_now = DIV_38400;
    endcase
  end

  // Each state issues its bus cycle on the edge that leaves it, so the
  // registered bus outputs are valid for the cycle that follows.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= CFG_HI;
      iocs_reg   <= 1'b0;
      iorw_reg   <= 1'b1;
      ioaddr_reg <= 2'b00;
      data_reg   <= 8'h00;
      hold_reg   <= 8'h00;
      div_reg    <= 16'h0000;
      dirty_reg  <= 1'b0;
    end else begin
      iocs_reg   <= 1'b0;
      iorw_reg   <= 1'b1;
      ioaddr_reg <= 2'b00;

      if (cfg_change)
        dirty_reg <= 1'b1;
      else if (state_reg == IDLE)
        dirty_reg <= 1'b0;

      // Read cycle closes on this edge: spart is driving the bus now.
      if (iocs_reg && iorw_reg)
        hold_reg <= fold(databus);

      case (state_reg)
        CFG_HI: begin
          iocs_reg   <= 1'b1;
          iorw_reg   <= 1'b0;
          ioaddr_reg <= 2'b11;
          div_reg    <= div_now;
          data_reg   <= div_now[15:8];
          state_reg  <= CFG_LO;
        end
        CFG_LO: begin
          iocs_reg   <= 1'b1;
          iorw_reg   <= 1'b0;
          ioaddr_reg <= 2'b10;
          data_reg   <= div_reg[7:0];
          state_reg  <= IDLE;
        end
        IDLE: begin
          if (dirty_reg)
            state_reg <= CFG_HI;
          else if (io.rda)
            state_reg <= RD_RX;
        end
        RD_RX: begin
          iocs_reg   <= 1'b1;
          iorw_reg   <= 1'b1;
          ioaddr_reg <= 2'b00;
          state_reg  <= WAIT_TBR;
        end
        WAIT_TBR: begin
          if (io.tbr)
            state_reg <= WR_TX;
        end
        WR_TX: begin
          iocs_reg   <= 1'b1;
          iorw_reg   <= 1'b0;
          ioaddr_reg <= 2'b00;
          data_reg   <= hold_reg;
          state_reg  <= HOLDOFF;
        end
        HOLDOFF:  state_reg <= IDLE;
        default:  state_reg <= IDLE;
      endcase
    end
  end

  assign io.iocs   = iocs_reg;
  assign io.iorw   = iorw_reg;
  assign io.ioaddr = ioaddr_reg;
  assign databus   = (iocs_reg && !iorw_reg) ? data_reg : 8'hzz;
endmodule
